dma_stream_fifo: RTL and testbench

Parametrised synchronous FIFO for the DMA datapath, placed between the AHB read engine and the write engine.
- Both sides use valid/ready handshakes; read side is show-ahead (first-word fall-through).
- Supports any depth ≥ 2, not only powers of two.
- Outputs occupancy count, full and empty, and a hysteresis burst-permission flag that paces AHB bursts.

---
 rtl/dma_stream_fifo.sv | 115 +++++++++++
 tb/tb_dma_stream_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_stream_fifo.sv
// Show-ahead valid/ready FIFO between the AHB read and write engines, any DEPTH >= 2.
// Optional sticky overflow/underflow flags are compiled in with DMA_FIFO_ERR_FLAGS_EN.
module dma_stream_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned LOW_MARK   = 2,
   parameter int unsigned HIGH_MARK  = 6
) (
   input  logic                           clk,
   input  logic                           areset,
   input  logic                           flush_i,
   input  logic [DATA_WIDTH-1:0]          wr_data_i,
   input  logic                           wr_valid_i,
   output logic                           wr_ready_o,
   output logic [DATA_WIDTH-1:0]          rd_data_o,
   output logic                           rd_valid_o,
   input  logic                           rd_ready_i,
`ifdef DMA_FIFO_ERR_FLAGS_EN
   input  logic                           err_clr_i,
   output logic                           overflow_o,
   output logic                           underflow_o,
`endif
   output logic [$clog2(DEPTH+1)-1:0]     count_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic                           burst_ok_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count_q, count_next;
   logic                  full_q, empty_q, burst_q, burst_next;
   logic                  wr_en, rd_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Flush drops both handshakes in the same cycle.
   assign wr_en = wr_valid_i & ~full_q  & ~flush_i;
   assign rd_en = rd_ready_i & ~empty_q & ~flush_i;

   always_comb begin
      count_next = count_q;
      if (flush_i)
         count_next = '0;
      else if (wr_en && !rd_en)
         count_next = count_q + CW'(1);
      else if (rd_en && !wr_en)
         count_next = count_q - CW'(1);
   end

   always_comb begin
      burst_next = burst_q;
      if (count_next <= CW'(LOW_MARK))
         burst_next = 1'b1;
      else if (count_next >= CW'(HIGH_MARK))
         burst_next = 1'b0;
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         burst_q <= 1'b1;
      end else begin
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
         end
         count_q <= count_next;
         full_q  <= (count_next == CW'(DEPTH));
         empty_q <= (count_next == '0);
         burst_q <= burst_next;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data_i;
   end

   assign rd_data_o  = mem[rd_ptr];
   assign rd_valid_o = ~empty_q;
   assign wr_ready_o = ~full_q;
   assign count_o    = count_q;
   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign burst_ok_o = burst_q;

`ifdef DMA_FIFO_ERR_FLAGS_EN
   // Set beats clear; flush leaves the flags alone.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         if (wr_valid_i && full_q)      overflow_o <= 1'b1;
         else if (err_clr_i)            overflow_o <= 1'b0;
         if (rd_ready_i && empty_q)     underflow_o <= 1'b1;
         else if (err_clr_i)            underflow_o <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_dma_stream_fifo.sv
// Directed bench for dma_stream_fifo: one 8-deep/32-bit instance and one 5-deep/8-bit instance.
module tb_dma_stream_fifo;

   logic clk = 1'b0;
   logic areset;
   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // 8-deep instance
   logic        flush, wvalid, rready, wready, rvalid, full, empty, burst;
   logic [31:0] wdata, rdata;
   logic [3:0]  count;
   // 5-deep instance
   logic        f5_flush, f5_wvalid, f5_rready, f5_wready, f5_rvalid, f5_full, f5_empty, f5_burst;
   logic [7:0]  f5_wdata, f5_rdata;
   logic [2:0]  f5_count;
`ifdef DMA_FIFO_ERR_FLAGS_EN
   logic err_clr, ovf, udf, f5_err_clr, f5_ovf, f5_udf;
`endif

   dma_stream_fifo #(.DATA_WIDTH(32), .DEPTH(8), .LOW_MARK(2), .HIGH_MARK(6)) dut8 (
      .clk(clk), .areset(areset), .flush_i(flush),
      .wr_data_i(wdata), .wr_valid_i(wvalid), .wr_ready_o(wready),
      .rd_data_o(rdata), .rd_valid_o(rvalid), .rd_ready_i(rready),
`ifdef DMA_FIFO_ERR_FLAGS_EN
      .err_clr_i(err_clr), .overflow_o(ovf), .underflow_o(udf),
`endif
      .count_o(count), .full_o(full), .empty_o(empty), .burst_ok_o(burst)
   );

   dma_stream_fifo #(.DATA_WIDTH(8), .DEPTH(5), .LOW_MARK(1), .HIGH_MARK(4)) dut5 (
      .clk(clk), .areset(areset), .flush_i(f5_flush),
      .wr_data_i(f5_wdata), .wr_valid_i(f5_wvalid), .wr_ready_o(f5_wready),
      .rd_data_o(f5_rdata), .rd_valid_o(f5_rvalid), .rd_ready_i(f5_rready),
`ifdef DMA_FIFO_ERR_FLAGS_EN
      .err_clr_i(f5_err_clr), .overflow_o(f5_ovf), .underflow_o(f5_udf),
`endif
      .count_o(f5_count), .full_o(f5_full), .empty_o(f5_empty), .burst_ok_o(f5_burst)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      tick();
      tick();
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if ({full, empty, wready, rvalid, burst} !== 5'b01101) begin
         bad++; $display("FAIL reset_flags got=%b exp=01101", {full, empty, wready, rvalid, burst});
      end
      total++; if ({f5_count, f5_empty, f5_burst} !== 5'b00011) begin
         bad++; $display("FAIL reset_f5 got=%b exp=00011", {f5_count, f5_empty, f5_burst});
      end
      areset = 1'b0;
      tick();
   endtask

   task automatic test_fill_drain();
      wvalid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wdata = 32'(i);
         tick();
         total++; if (count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
         if (i == 0) begin
            total++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin
               bad++; $display("FAIL first_word_latency got=%b/%h exp=1/00000000", rvalid, rdata);
            end
         end
      end
      wvalid = 1'b0;
      total++; if ({full, wready} !== 2'b10) begin bad++; $display("FAIL full_after_8 got=%b exp=10", {full, wready}); end
      rready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++; if (rvalid !== 1'b1 || rdata !== 32'(i)) begin
            bad++; $display("FAIL drain_data got=%b/%h exp=1/%h", rvalid, rdata, 32'(i));
         end
         tick();
      end
      rready = 1'b0;
      total++; if ({empty, count} !== 5'b10000) begin bad++; $display("FAIL drain_empty got=%b exp=10000", {empty, count}); end
   endtask

   task automatic test_back_to_back();
      wvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wdata = 32'h100 + 32'(i);
         tick();
      end
      rready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         wdata = 32'h104 + 32'(k);
         total++; if (rdata !== 32'h100 + 32'(k)) begin
            bad++; $display("FAIL b2b_data got=%h exp=%h", rdata, 32'h100 + 32'(k));
         end
         tick();
         total++; if (count !== 4'd4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", count); end
      end
      wvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         total++; if (rdata !== 32'h114 + 32'(k)) begin
            bad++; $display("FAIL b2b_tail got=%h exp=%h", rdata, 32'h114 + 32'(k));
         end
         tick();
      end
      rready = 1'b0;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
   endtask

   task automatic test_full_rw();
      wvalid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wdata = 32'h200 + 32'(i);
         tick();
      end
      wdata  = 32'hDEAD;
      rready = 1'b1;
      total++; if (rdata !== 32'h200) begin bad++; $display("FAIL fullrw_head got=%h exp=00000200", rdata); end
      tick();
      wvalid = 1'b0;
      total++; if ({count, wready, full} !== 6'b0111_10) begin
         bad++; $display("FAIL fullrw_state got=%b exp=011110", {count, wready, full});
      end
      for (int i = 1; i < 8; i++) begin
         total++; if (rdata !== 32'h200 + 32'(i)) begin
            bad++; $display("FAIL fullrw_drain got=%h exp=%h", rdata, 32'h200 + 32'(i));
         end
         tick();
      end
      rready = 1'b0;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL fullrw_empty got=%b exp=1", empty); end
   endtask

   task automatic test_burst();
      logic exp;
      wvalid = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         wdata = 32'(c);
         tick();
         exp = (c >= 6) ? 1'b0 : 1'b1;
         total++; if (burst !== exp) begin bad++; $display("FAIL burst_fill c=%0d got=%b exp=%b", c, burst, exp); end
      end
      wvalid = 1'b0;
      rready = 1'b1;
      for (int c = 7; c >= 0; c--) begin
         tick();
         exp = (c <= 2) ? 1'b1 : 1'b0;
         total++; if (burst !== exp) begin bad++; $display("FAIL burst_drain c=%0d got=%b exp=%b", c, burst, exp); end
      end
      rready = 1'b0;
   endtask

   task automatic test_flush();
      wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wdata = 32'h300 + 32'(i);
         tick();
      end
      total++; if (count !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d exp=5", count); end
      flush = 1'b1; wdata = 32'hBAD; rready = 1'b1;
      tick();
      flush = 1'b0; wvalid = 1'b0; rready = 1'b0;
      total++; if ({count, empty, full, burst, rvalid} !== 8'b0000_1010) begin
         bad++; $display("FAIL flush_state got=%b exp=00001010", {count, empty, full, burst, rvalid});
      end
      wvalid = 1'b1; wdata = 32'h333;
      tick();
      wvalid = 1'b0;
      total++; if (count !== 4'd1 || rdata !== 32'h333) begin
         bad++; $display("FAIL flush_after got=%0d/%h exp=1/00000333", count, rdata);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_final got=%b exp=1", empty); end
   endtask

   task automatic test_depth5();
      f5_wvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         f5_wdata = 8'h50 + 8'(i);
         tick();
      end
      total++; if ({f5_count, f5_burst} !== 4'b0111) begin
         bad++; $display("FAIL d5_pre got=%b exp=0111", {f5_count, f5_burst});
      end
      f5_rready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         f5_wdata = 8'h53 + 8'(k);
         total++; if (f5_rdata !== 8'h50 + 8'(k)) begin
            bad++; $display("FAIL d5_wrap got=%h exp=%h", f5_rdata, 8'h50 + 8'(k));
         end
         tick();
      end
      f5_wvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++; if (f5_rdata !== 8'h59 + 8'(k)) begin
            bad++; $display("FAIL d5_tail got=%h exp=%h", f5_rdata, 8'h59 + 8'(k));
         end
         tick();
      end
      f5_rready = 1'b0;
      total++; if ({f5_count, f5_empty} !== 4'b0001) begin
         bad++; $display("FAIL d5_empty got=%b exp=0001", {f5_count, f5_empty});
      end
      f5_wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         f5_wdata = 8'hA0 + 8'(i);
         tick();
      end
      total++; if ({f5_count, f5_full, f5_wready, f5_burst} !== 6'b101_100) begin
         bad++; $display("FAIL d5_full got=%b exp=101100", {f5_count, f5_full, f5_wready, f5_burst});
      end
`ifdef DMA_FIFO_ERR_FLAGS_EN
      f5_wdata = 8'hEE;
      tick();
      f5_wvalid = 1'b0;
      total++; if (f5_ovf !== 1'b1) begin bad++; $display("FAIL d5_ovf_set got=%b exp=1", f5_ovf); end
      f5_err_clr = 1'b1;
      tick();
      f5_err_clr = 1'b0;
      total++; if (f5_ovf !== 1'b0) begin bad++; $display("FAIL d5_ovf_clr got=%b exp=0", f5_ovf); end
`endif
      f5_wvalid = 1'b0;
      f5_rready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         total++; if (f5_rdata !== 8'hA0 + 8'(i)) begin
            bad++; $display("FAIL d5_drain got=%h exp=%h", f5_rdata, 8'hA0 + 8'(i));
         end
         tick();
      end
      total++; if ({f5_empty, f5_burst} !== 2'b11) begin
         bad++; $display("FAIL d5_end got=%b exp=11", {f5_empty, f5_burst});
      end
`ifdef DMA_FIFO_ERR_FLAGS_EN
      tick();
      total++; if (f5_udf !== 1'b1) begin bad++; $display("FAIL d5_udf_set got=%b exp=1", f5_udf); end
`endif
      f5_rready = 1'b0;
   endtask

   task automatic test_reset_mid();
      wvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wdata = 32'h400 + 32'(i);
         tick();
      end
      #2 areset = 1'b1;
      #1;
      total++; if ({count, empty, rvalid, wready} !== 7'b0000_101) begin
         bad++; $display("FAIL mid_reset got=%b exp=0000101", {count, empty, rvalid, wready});
      end
      wvalid = 1'b0;
      tick();
      areset = 1'b0;
      tick();
      total++; if (count !== 4'd0) begin bad++; $display("FAIL post_reset got=%0d exp=0", count); end
   endtask

   initial begin
      areset = 1'b1;
      flush = 1'b0; wvalid = 1'b0; rready = 1'b0; wdata = '0;
      f5_flush = 1'b0; f5_wvalid = 1'b0; f5_rready = 1'b0; f5_wdata = '0;
`ifdef DMA_FIFO_ERR_FLAGS_EN
      err_clr = 1'b0; f5_err_clr = 1'b0;
`endif
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_full_rw();
      test_burst();
      test_flush();
      test_depth5();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
